// File: rtl/id_stage.sv
// id_stage: RV32I decode/operand-fetch stage with register file read, writeback forwarding and immediate generation
module id_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_pc,
  input  logic [XLEN-1:0]       in_inst,
  output logic                  rf_re1,
  output logic                  rf_re2,
  output logic [REG_ADDR_W-1:0] rf_raddr1,
  output logic [REG_ADDR_W-1:0] rf_raddr2,
  input  logic [XLEN-1:0]       rf_rdata1,
  input  logic [XLEN-1:0]       rf_rdata2,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_waddr,
  input  logic [XLEN-1:0]       wb_wdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_pc,
  output logic [6:0]            out_opcode,
  output logic [2:0]            out_funct3,
  output logic [6:0]            out_funct7,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_rd_we,
  output logic [XLEN-1:0]       out_imm,
  output logic [XLEN-1:0]       out_op1,
  output logic [XLEN-1:0]       out_op2,
  output logic                  out_illegal
);
  typedef enum logic [1:0] {IDLE, OPS, HOLD} state_t;
  state_t state_q, state_d;
  logic accept, use1, use2, wrd, ill, bhit1, bhit2, hit1, hit2;
  logic [6:0] opc;
  logic [REG_ADDR_W-1:0] rs1_dec, rs2_dec, rs1_q, rs2_q, rd_q;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm;
  logic byp1_q, byp2_q, rd_we_q, illegal_q;
  logic [XLEN-1:0] byp1_data_q, byp2_data_q, pc_q, imm_q, op1_q, op2_q, op1_d, op2_d;
  logic [6:0] opcode_q, funct7_q;
  logic [2:0] funct3_q;
  assign opc = in_inst[6:0];
  assign imm_i = XLEN'($signed(in_inst[31:20]));
  assign imm_s = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
  assign imm_b = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({in_inst[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));
  // Opcode class: which source registers are read, whether rd is written, immediate format
  always_comb begin
    use1 = 1'b0;
    use2 = 1'b0;
    wrd  = 1'b0;
    ill  = 1'b0;
    imm  = '0;
    case (opc)
      7'b0110011: begin use1 = 1'b1; use2 = 1'b1; wrd = 1'b1; end
      7'b0010011, 7'b0000011, 7'b1100111: begin use1 = 1'b1; wrd = 1'b1; imm = imm_i; end
      7'b0100011: begin use1 = 1'b1; use2 = 1'b1; imm = imm_s; end
      7'b1100011: begin use1 = 1'b1; use2 = 1'b1; imm = imm_b; end
      7'b0110111, 7'b0010111: begin wrd = 1'b1; imm = imm_u; end
      7'b1101111: begin wrd = 1'b1; imm = imm_j; end
      7'b0001111, 7'b1110011: begin end
      default: ill = 1'b1;
    endcase
  end
  assign rs1_dec   = use1 ? in_inst[19:15] : '0;
  assign rs2_dec   = use2 ? in_inst[24:20] : '0;
  assign rf_raddr1 = in_inst[19:15];
  assign rf_raddr2 = in_inst[24:20];
  assign in_ready  = !flush && (state_q == IDLE || (state_q == HOLD && out_ready));
  assign accept    = in_valid && in_ready;
  assign rf_re1    = accept && rs1_dec != '0;
  assign rf_re2    = accept && rs2_dec != '0;
  assign bhit1     = wb_we && rs1_dec != '0 && wb_waddr == rs1_dec;
  assign bhit2     = wb_we && rs2_dec != '0 && wb_waddr == rs2_dec;
  assign hit1      = wb_we && rs1_q != '0 && wb_waddr == rs1_q;
  assign hit2      = wb_we && rs2_q != '0 && wb_waddr == rs2_q;
  // Next state and operand resolution: OPS picks the freshest source, HOLD keeps snooping writes
  always_comb begin
    state_d = flush ? IDLE : accept ? OPS : state_q == OPS ? HOLD : (state_q == HOLD && out_ready) ? IDLE : state_q;
    op1_d = (state_q == OPS && !flush) ? (hit1 ? wb_wdata : byp1_q ? byp1_data_q : rs1_q != '0 ? rf_rdata1 : '0)
          : (state_q == HOLD && hit1) ? wb_wdata : op1_q;
    op2_d = (state_q == OPS && !flush) ? (hit2 ? wb_wdata : byp2_q ? byp2_data_q : rs2_q != '0 ? rf_rdata2 : '0)
          : (state_q == HOLD && hit2) ? wb_wdata : op2_q;
  end
  // Pipeline registers: decode latched at accept, operands at the following edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      rs1_q       <= '0;
      rs2_q       <= '0;
      byp1_q      <= 1'b0;
      byp2_q      <= 1'b0;
      byp1_data_q <= '0;
      byp2_data_q <= '0;
      pc_q        <= '0;
      opcode_q    <= '0;
      funct3_q    <= '0;
      funct7_q    <= '0;
      rd_q        <= '0;
      rd_we_q     <= 1'b0;
      imm_q       <= '0;
      illegal_q   <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
    end else begin
      state_q <= state_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      if (accept) begin
        rs1_q       <= rs1_dec;
        rs2_q       <= rs2_dec;
        byp1_q      <= bhit1;
        byp2_q      <= bhit2;
        byp1_data_q <= wb_wdata;
        byp2_data_q <= wb_wdata;
        pc_q        <= in_pc;
        opcode_q    <= opc;
        funct3_q    <= in_inst[14:12];
        funct7_q    <= in_inst[31:25];
        rd_q        <= in_inst[11:7];
        rd_we_q     <= wrd && in_inst[11:7] != '0;
        imm_q       <= imm;
        illegal_q   <= ill;
      end
    end
  end
  assign out_valid   = state_q == HOLD;
  assign out_pc      = pc_q;
  assign out_opcode  = opcode_q;
  assign out_funct3  = funct3_q;
  assign out_funct7  = funct7_q;
  assign out_rd      = rd_q;
  assign out_rd_we   = rd_we_q;
  assign out_imm     = imm_q;
  assign out_op1     = op1_q;
  assign out_op2     = op2_q;
  assign out_illegal = illegal_q;
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: randomized self-checking bench for id_stage against an architectural register model
module tb_id_stage;
  logic clk = 1'b0, rst = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1, wb_we = 1'b0;
  logic [31:0] in_pc = '0, in_inst = '0, rf_rdata1 = '0, rf_rdata2 = '0, wb_wdata = '0;
  logic [4:0] wb_waddr = '0;
  logic in_ready, rf_re1, rf_re2, out_valid, out_rd_we, out_illegal;
  logic [4:0] rf_raddr1, rf_raddr2, out_rd;
  logic [31:0] out_pc, out_imm, out_op1, out_op2;
  logic [6:0] out_opcode, out_funct7;
  logic [2:0] out_funct3;
  int checks = 0, errors = 0;
  logic [31:0] regs [32];

  typedef struct packed {
    logic [31:0] pc; logic [6:0] opc; logic [2:0] f3; logic [6:0] f7; logic [4:0] rd; logic rd_we;
    logic [31:0] imm; logic [31:0] op1; logic [31:0] op2; logic ill;
  } pkt_t;
  typedef struct packed {logic u1; logic u2; logic w; logic ill; logic [2:0] fmt;} cls_t;
  pkt_t obs;
  assign obs = {out_pc, out_opcode, out_funct3, out_funct7, out_rd, out_rd_we, out_imm, out_op1, out_op2, out_illegal};

  id_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .rf_re1(rf_re1), .rf_re2(rf_re2), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_opcode(out_opcode), .out_funct3(out_funct3),
    .out_funct7(out_funct7), .out_rd(out_rd), .out_rd_we(out_rd_we), .out_imm(out_imm),
    .out_op1(out_op1), .out_op2(out_op2), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  // Instruction classes: reads rs1/rs2, writes rd, illegal, immediate format (1=I 2=S 3=B 4=U 5=J)
  function automatic cls_t classify(input logic [6:0] opc);
    case (opc)
      7'h33:               return '{1'b1, 1'b1, 1'b1, 1'b0, 3'd0};
      7'h13, 7'h03, 7'h67: return '{1'b1, 1'b0, 1'b1, 1'b0, 3'd1};
      7'h23:               return '{1'b1, 1'b1, 1'b0, 1'b0, 3'd2};
      7'h63:               return '{1'b1, 1'b1, 1'b0, 1'b0, 3'd3};
      7'h37, 7'h17:        return '{1'b0, 1'b0, 1'b1, 1'b0, 3'd4};
      7'h6F:               return '{1'b0, 1'b0, 1'b1, 1'b0, 3'd5};
      7'h0F, 7'h73:        return '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
      default:             return '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0};
    endcase
  endfunction

  // Expected packet: operands are the current architectural register values
  function automatic pkt_t model(input logic [31:0] pc, input logic [31:0] inst);
    cls_t c;
    pkt_t p;
    c = classify(inst[6:0]);
    p.pc = pc; p.opc = inst[6:0]; p.f3 = inst[14:12]; p.f7 = inst[31:25]; p.rd = inst[11:7];
    p.rd_we = c.w && inst[11:7] != 5'd0;
    case (c.fmt)
      3'd1:    p.imm = {{20{inst[31]}}, inst[31:20]};
      3'd2:    p.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      3'd3:    p.imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      3'd4:    p.imm = {inst[31:12], 12'h000};
      3'd5:    p.imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: p.imm = 32'h0;
    endcase
    p.op1 = c.u1 ? regs[inst[19:15]] : 32'h0;
    p.op2 = c.u2 ? regs[inst[24:20]] : 32'h0;
    p.ill = c.ill;
    return p;
  endfunction

  function automatic logic [1:0] exp_re(input logic [31:0] inst);
    cls_t c;
    c = classify(inst[6:0]);
    return {c.u1 && inst[19:15] != 5'd0, c.u2 && inst[24:20] != 5'd0};
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0] tbl [12];
    logic [31:0] v;
    tbl = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h0F, 7'h73, 7'h7F};
    v = $urandom;
    v[6:0] = tbl[$urandom_range(0, 11)];
    if ($urandom_range(0, 3) != 0) begin
      v[19:15] = 5'($urandom_range(0, 7));
      v[24:20] = 5'($urandom_range(0, 7));
    end
    return v;
  endfunction

  // Acts as the register file: registered read returns the value before any same-edge write
  task automatic issue(input logic [31:0] pc, input logic [31:0] inst,
                       input logic w1we, input logic [4:0] w1a, input logic [31:0] w1d,
                       input logic w2we, input logic [4:0] w2a, input logic [31:0] w2d,
                       output logic rdy, output logic [1:0] re);
    logic [31:0] s1, s2;
    in_valid = 1'b1; in_pc = pc; in_inst = inst; wb_we = w1we; wb_waddr = w1a; wb_wdata = w1d;
    #1;
    rdy = in_ready; re = {rf_re1, rf_re2};
    s1 = regs[inst[19:15]]; s2 = regs[inst[24:20]];
    @(posedge clk);
    if (w1we && w1a != 5'd0) regs[w1a] = w1d;
    @(negedge clk);
    in_valid = 1'b0; wb_we = w2we; wb_waddr = w2a; wb_wdata = w2d;
    rf_rdata1 = re[1] ? s1 : $urandom;
    rf_rdata2 = re[0] ? s2 : $urandom;
    @(posedge clk);
    if (w2we && w2a != 5'd0) regs[w2a] = w2d;
    @(negedge clk);
    wb_we = 1'b0; rf_rdata1 = $urandom; rf_rdata2 = $urandom;
  endtask

  task automatic drain();
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (obs !== '0) begin errors++; $display("FAIL reset_outs: got %h want 0", obs); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    checks++; if ({rf_re1, rf_re2} !== 2'b00) begin errors++; $display("FAIL reset_re: got %b want 00", {rf_re1, rf_re2}); end
  endtask

  task automatic test_add();
    logic rdy; logic [1:0] re;
    regs[1] = 32'd5; regs[2] = 32'd7;
    issue(32'h100, 32'h002081B3, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, rdy, re);
    checks++; if ({rdy, re} !== 3'b111) begin errors++; $display("FAIL add_accept: got %b want 111", {rdy, re}); end
    checks++; if ({rf_raddr1, rf_raddr2} !== {5'd1, 5'd2}) begin errors++; $display("FAIL add_raddr: got %h want 0022", {rf_raddr1, rf_raddr2}); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b want 1", out_valid); end
    checks++; if ({out_op1, out_op2, out_rd, out_rd_we, out_pc, out_imm} !== {32'd5, 32'd7, 5'd3, 1'b1, 32'h100, 32'h0})
      begin errors++; $display("FAIL add_fields: got %h want %h", {out_op1, out_op2, out_rd, out_rd_we, out_pc, out_imm}, {32'd5, 32'd7, 5'd3, 1'b1, 32'h100, 32'h0}); end
    checks++; if (obs !== model(32'h100, 32'h002081B3)) begin errors++; $display("FAIL add_pkt: got %h want %h", obs, model(32'h100, 32'h002081B3)); end
    drain();
  endtask

  task automatic test_bypass();
    logic rdy; logic [1:0] re;
    regs[1] = 32'd5; regs[2] = 32'd7;
    issue(32'h104, 32'h002081B3, 1'b1, 5'd1, 32'h99, 1'b0, 5'd0, 32'd0, rdy, re);
    checks++; if (out_op1 !== 32'h99) begin errors++; $display("FAIL byp_accept_op1: got %h want 99", out_op1); end
    checks++; if (obs !== model(32'h104, 32'h002081B3)) begin errors++; $display("FAIL byp_accept_pkt: got %h want %h", obs, model(32'h104, 32'h002081B3)); end
    drain();
    regs[1] = 32'd5;
    issue(32'h108, 32'h002081B3, 1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 32'h99, rdy, re);
    checks++; if (out_op1 !== 32'h99) begin errors++; $display("FAIL byp_ops_op1: got %h want 99", out_op1); end
    checks++; if (obs !== model(32'h108, 32'h002081B3)) begin errors++; $display("FAIL byp_ops_pkt: got %h want %h", obs, model(32'h108, 32'h002081B3)); end
    drain();
  endtask

  task automatic test_hold_snoop();
    logic rdy; logic [1:0] re;
    regs[1] = 32'd5; regs[2] = 32'd7;
    issue(32'h10C, 32'h002081B3, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, rdy, re);
    out_ready = 1'b0; wb_we = 1'b1; wb_waddr = 5'd2; wb_wdata = 32'h42;
    @(posedge clk);
    regs[2] = 32'h42;
    @(negedge clk);
    wb_we = 1'b0;
    checks++; if ({out_valid, out_op2} !== {1'b1, 32'h42}) begin errors++; $display("FAIL hold_snoop: got %h want 100000042", {out_valid, out_op2}); end
    checks++; if (obs !== model(32'h10C, 32'h002081B3)) begin errors++; $display("FAIL hold_pkt: got %h want %h", obs, model(32'h10C, 32'h002081B3)); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (obs !== model(32'h10C, 32'h002081B3)) begin errors++; $display("FAIL hold_stable: got %h want %h", obs, model(32'h10C, 32'h002081B3)); end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_release: got %b want 0", out_valid); end
  endtask

  task automatic test_decode();
    logic rdy; logic [1:0] re;
    logic [31:0] insts [3], imms [3];
    logic ills [3];
    insts = '{32'hFFF00293, 32'h123450B7, 32'h0000007F};
    imms  = '{32'hFFFFFFFF, 32'h12345000, 32'h0};
    ills  = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      issue(32'h200 + 32'(i * 4), insts[i], 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, rdy, re);
      checks++; if (re !== 2'b00) begin errors++; $display("FAIL dec_re[%0d]: got %b want 00", i, re); end
      checks++; if ({out_imm, out_illegal, out_op1} !== {imms[i], ills[i], 32'h0})
        begin errors++; $display("FAIL dec_imm[%0d]: got %h want %h", i, {out_imm, out_illegal, out_op1}, {imms[i], ills[i], 32'h0}); end
      checks++; if (obs !== model(32'h200 + 32'(i * 4), insts[i])) begin errors++; $display("FAIL dec_pkt[%0d]: got %h want %h", i, obs, model(32'h200 + 32'(i * 4), insts[i])); end
      drain();
    end
    checks++; if (out_rd_we !== 1'b0) begin errors++; $display("FAIL dec_ill_rdwe: got %b want 0", out_rd_we); end
  endtask

  task automatic test_back_to_back();
    logic rdy; logic [1:0] re;
    logic [31:0] inst;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      inst = rand_inst();
      issue(32'h300 + 32'(i * 4), inst, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, rdy, re);
      checks++; if ({rdy, re, out_valid} !== {1'b1, exp_re(inst), 1'b1}) begin errors++; $display("FAIL b2b_hs[%0d]: got %b want %b", i, {rdy, re, out_valid}, {1'b1, exp_re(inst), 1'b1}); end
      checks++; if (obs !== model(32'h300 + 32'(i * 4), inst)) begin errors++; $display("FAIL b2b_pkt[%0d]: got %h want %h", i, obs, model(32'h300 + 32'(i * 4), inst)); end
    end
    drain();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", out_valid); end
  endtask

  task automatic test_random();
    logic rdy; logic [1:0] re;
    logic [31:0] inst, pc, d;
    logic [4:0] a;
    logic we;
    for (int i = 0; i < 40; i++) begin
      inst = rand_inst(); pc = $urandom;
      out_ready = 1'b1;
      issue(pc, inst, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom, rdy, re);
      checks++; if ({rdy, re, out_valid} !== {1'b1, exp_re(inst), 1'b1}) begin errors++; $display("FAIL rnd_hs[%0d]: got %b want %b", i, {rdy, re, out_valid}, {1'b1, exp_re(inst), 1'b1}); end
      checks++; if (obs !== model(pc, inst)) begin errors++; $display("FAIL rnd_pkt[%0d]: got %h want %h", i, obs, model(pc, inst)); end
      for (int h = $urandom_range(0, 2); h > 0; h--) begin
        out_ready = 1'b0; we = 1'($urandom_range(0, 1)); a = 5'($urandom_range(0, 7)); d = $urandom;
        wb_we = we; wb_waddr = a; wb_wdata = d;
        @(posedge clk);
        if (we && a != 5'd0) regs[a] = d;
        @(negedge clk);
        wb_we = 1'b0;
        checks++; if ({out_valid, obs} !== {1'b1, model(pc, inst)}) begin errors++; $display("FAIL rnd_hold[%0d]: got %h want %h", i, {out_valid, obs}, {1'b1, model(pc, inst)}); end
      end
    end
    drain();
  endtask

  task automatic test_flush();
    logic rdy; logic [1:0] re;
    regs[1] = 32'd5; regs[2] = 32'd7;
    in_valid = 1'b1; in_pc = 32'h400; in_inst = 32'h002081B3;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    #1;
    checks++; if ({in_ready, rf_re1, rf_re2} !== 3'b000) begin errors++; $display("FAIL flush_ready: got %b want 000", {in_ready, rf_re1, rf_re2}); end
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL flush_idle: got %b want 01", {out_valid, in_ready}); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_nopkt: got %b want 0", out_valid); end
    issue(32'h404, 32'h002081B3, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, rdy, re);
    out_ready = 1'b0; flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_hold: got %b want 0", out_valid); end
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'h0 : $urandom;
    @(negedge clk);
    test_reset();
    test_add();
    test_bypass();
    test_hold_snoop();
    test_decode();
    test_back_to_back();
    test_random();
    test_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode/operand-fetch stage sitting directly upstream of the register file.
- Accepts one RV32I instruction via valid/ready and drives the register file read port (registered read, 1-cycle latency).
- Forwards in-flight writeback data, forces x0 to zero, generates the immediate, and presents a decoded packet to execute via valid/ready.

Parameters:
- XLEN, 32, data/PC/instruction width
- REG_ADDR_W, 5, register address width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- flush  in  1  synchronous pipeline kill
- in_valid  in  1  instruction valid
- in_ready  out  1  stage can accept
- in_pc  in  XLEN  instruction PC
- in_inst  in  XLEN  instruction word
- rf_re1 / rf_re2  out  1  register file read enables
- rf_raddr1 / rf_raddr2  out  REG_ADDR_W  read addresses
- rf_rdata1 / rf_rdata2  in  XLEN  read data, valid the cycle after the read edge
- wb_we, wb_waddr, wb_wdata  in  1/REG_ADDR_W/XLEN  snooped register file write port
- out_valid  out  1  packet valid
- out_ready  in  1  execute accepts
- out_pc  out  XLEN
- out_opcode  out  7
- out_funct3  out  3
- out_funct7  out  7
- out_rd  out  REG_ADDR_W
- out_rd_we  out  1
- out_imm  out  XLEN
- out_op1 / out_op2  out  XLEN  resolved rs1/rs2 values
- out_illegal  out  1  unknown opcode

Behaviour:
- Reset (rst=0 at posedge): state IDLE; out_valid=0; all out_* registers=0; bypass flags cleared. rf_re* are combinational, so they are 0 whenever in_ready=0 or in_valid=0.
- FSM states:
  - IDLE: in_ready=1.
  - OPS: in_ready=0, out_valid=0.
  - HOLD: out_valid=1, in_ready=out_ready.
- Transitions:
  - accept (in_valid & in_ready) -> OPS.
  - OPS -> HOLD unconditionally.
  - HOLD & out_ready -> OPS if accepting in the same cycle, else IDLE.
- Timing: accept at edge N; operands captured at edge N+1; out_valid from edge N+1. Throughput is 1 instruction per 2 cycles.
- Read port:
  - rf_raddr1=in_inst[19:15] and rf_raddr2=in_inst[24:20], always driven.
  - rf_reX = in_valid & in_ready & needs_rsX & (rsX!=0).
- Decode at accept, latched at edge N:
  - R (0110011): rs1, rs2, rd.
  - OP-IMM (0010011), LOAD (0000011), JALR (1100111): rs1, rd.
  - STORE (0100011), BRANCH (1100011): rs1, rs2.
  - LUI (0110111), AUIPC (0010111), JAL (1101111): rd.
  - FENCE (0001111), SYSTEM (1110011): no reads, no rd.
  - Other opcodes: out_illegal=1, no reads, out_rd_we=0.
  - out_rd_we=1 only for rd-writing classes with rd!=0.
- Immediate, all sign-extended from inst[31]:
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: inst[31:12]<<12.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - R/FENCE/SYSTEM/illegal: 0.
- Operand resolution, per operand, latest write wins:
  - (a) Edge N: if wb_we & wb_waddr==rsX & rsX!=0, latch wb_wdata and set a bypass flag, because the register file returns the stale value.
  - (b) Edge N+1 (OPS): if wb_we & wb_waddr==rsX & rsX!=0, capture wb_wdata. Else if the bypass flag is set, capture the latched value. Else capture rf_rdataX.
  - (c) In HOLD, each matching wb write updates out_opX.
  - rsX==0 or rsX unused: operand=0, never forwarded.
- Output stability: out_* are stable while out_valid & !out_ready, except for the (c) snoop updates.
- flush: next state IDLE, out_valid=0. in_ready is forced to 0 during flush, so no accept occurs. Overrides all transitions. Reset has priority over flush.
- Reset or flush mid-OPS discards the pending read; late rf_rdata is ignored.

Test Plan:
- rst=0 for 2 cycles, then 1 -> out_valid=0, all out_*=0, in_ready=1, rf_re1=rf_re2=0.
- Accept ADD x3,x1,x2 (0x002081B3) at PC 0x100 -> rf_re1=rf_re2=1 with raddr 1/2 in the accept cycle. Bench returns 5/7 the next cycle -> one cycle later out_valid=1, op1=5, op2=7, out_rd=3, out_rd_we=1, out_pc=0x100, out_imm=0.
- Same ADD with wb_we=1, wb_waddr=1, wb_wdata=0x99 in the accept cycle, register file returning stale 5 -> op1=0x99. Repeat with the write in the OPS cycle -> op1=0x99.
- out_ready=0 holding the ADD packet; wb writes x2=0x42 -> op2=0x42, out_valid stays 1, other fields unchanged. Then out_ready=1 -> out_valid drops unless a new instruction is accepted.
- Immediate and decode checks:
  - ADDI x5,x0,-1 (0xFFF00293) -> rf_re1=0, op1=0, imm=0xFFFFFFFF.
  - LUI x1 (0x123450B7) -> imm=0x12345000, no reads.
  - 0x0000007F -> out_illegal=1, out_rd_we=0.
- Stream of 4 instructions with out_ready=1 -> one accepted every 2 cycles, in order. Assert flush during OPS -> no packet emitted, in_ready=0 that cycle, IDLE next.
